// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin owner selection for one shared UART transmitter.
// Captures one requester's byte, strobes tx_load, holds ownership until tx_done,
// then runs an optional inter-frame gap before re-arbitrating.
// Optional watchdog in WAIT: define UART_TX_ARB_TIMEOUT_EN to build it.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned GAP_CYCLES     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 4095
) (
    input  logic                       tx_clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] cur_id,
    output logic                       tx_load,
    output logic [7:0]                 tx_data,
    input  logic                       tx_done,
    output logic                       err_timeout
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StGap  = 2'd2;

    localparam logic [IdW-1:0]     LastRst = IdW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] OneReq  = NUM_REQ'(1);

    logic [1:0]         state_q, state_d;
    logic [7:0]         gap_q, gap_d;
    logic [IdW-1:0]     last_q, last_d;
    logic [IdW-1:0]     cur_id_q, cur_id_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               tx_load_q, tx_load_d;
    logic               busy_q, busy_d;

    logic               win_found;
    logic [IdW-1:0]     win_id;
    logic [IdW-1:0]     cand;
    logic               done_ok;
    logic               wd_fire;
    logic               frame_end;

    // Round-robin search: first set req bit going upward from last_q+1, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = IdW'((32'(last_q) + off) % NUM_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // tx_done is not honoured on the load cycle itself.
    assign done_ok   = (state_q == StWait) && tx_done && !tx_load_q;
    assign frame_end = done_ok || wd_fire;

    // Next-state and registered-output values.
    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        last_d    = last_q;
        cur_id_d  = cur_id_q;
        tx_data_d = tx_data_q;
        gnt_d     = '0;
        tx_load_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d   = StWait;
                    gnt_d     = OneReq << win_id;
                    tx_load_d = 1'b1;
                    tx_data_d = 8'(req_data >> {win_id, 3'b000});
                    cur_id_d  = win_id;
                    last_d    = win_id;
                end
            end
            StWait: begin
                if (frame_end) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = StGap;
                        gap_d   = 8'(GAP_CYCLES - 1);
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StGap: begin
                if (gap_q == 8'd0) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    // Main state and output registers.
    always_ff @(posedge tx_clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            gap_q     <= 8'd0;
            last_q    <= LastRst;
            cur_id_q  <= '0;
            tx_data_q <= 8'd0;
            gnt_q     <= '0;
            tx_load_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            last_q    <= last_d;
            cur_id_q  <= cur_id_d;
            tx_data_q <= tx_data_d;
            gnt_q     <= gnt_d;
            tx_load_q <= tx_load_d;
            busy_q    <= busy_d;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam logic [15:0] TimeoutLim = 16'(TIMEOUT_CYCLES);

    logic [15:0] wd_q, wd_d;
    logic        err_q;

    // Fires on the WAIT cycle whose increment would reach the limit.
    assign wd_fire = (state_q == StWait) && ((wd_q + 16'd1) == TimeoutLim);

    // Watchdog count: cleared on grant, advances every WAIT cycle.
    always_comb begin
        wd_d = wd_q;
        if (state_q == StIdle && win_found) begin
            wd_d = 16'd0;
        end else if (state_q == StWait) begin
            wd_d = wd_q + 16'd1;
        end
    end

    // Watchdog registers; a real tx_done on the same cycle suppresses the error.
    always_ff @(posedge tx_clk) begin
        if (!rst_n) begin
            wd_q  <= 16'd0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= wd_fire && !done_ok;
        end
    end

    assign err_timeout = err_q;
`else
    assign wd_fire     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    assign gnt     = gnt_q;
    assign tx_load = tx_load_q;
    assign tx_data = tx_data_q;
    assign cur_id  = cur_id_q;
    assign busy    = busy_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter among `NUM_REQ` byte producers. It accepts a byte from one requester, pulses the transmitter's load strobe, and holds ownership until the transmitter reports frame completion. It then applies an optional inter-frame gap and re-arbitrates. It sits between the command/status producers and the single transmitter instance on `tx_clk`.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2–16.
- `GAP_CYCLES`, default 0: idle `tx_clk` cycles inserted after each frame completes; legal range 0–255.
- `TIMEOUT_CYCLES`, default 4095: watchdog limit in WAIT; used only when the watchdog is compiled in.
- `tx_clk` input 1: the single clock; all logic is on its rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `req` input `NUM_REQ`: per-requester request; held high with stable data until granted.
- `req_data` input `8*NUM_REQ`: byte `i` is `req_data[8*i+7:8*i]`.
- `gnt` output `NUM_REQ`: one-cycle, one-hot pulse; the byte was captured on this cycle.
- `busy` output 1: high whenever state ≠ IDLE.
- `cur_id` output `$clog2(NUM_REQ)`: current owner index; valid while `busy`.
- `tx_load` output 1: one-cycle load strobe to the transmitter.
- `tx_data` output 8: byte for the transmitter; held stable from `tx_load` until completion.
- `tx_done` input 1: transmitter frame-complete pulse.
- `err_timeout` output 1: one-cycle pulse when the watchdog fires.

## Operation
- States:
  - IDLE: no frame in progress.
  - WAIT: frame in progress; waiting for `tx_done`.
  - GAP: inter-frame gap countdown.
- IDLE → WAIT when any `req` bit is high.
  - Winner is the first set bit searching upward from `last_id+1`, modulo `NUM_REQ`.
  - Registered on the transition: `gnt[winner]=1`, `tx_load=1`, `tx_data=req_data[winner]`, `cur_id=winner`, `last_id=winner`.
- WAIT → GAP on `tx_done` when `GAP_CYCLES>0`; the gap counter loads `GAP_CYCLES-1`.
- WAIT → IDLE on `tx_done` when `GAP_CYCLES==0`.
- GAP counts down to 0, then → IDLE.
- `tx_done` is sampled only in WAIT, and is ignored on the cycle `tx_load` is asserted. `tx_done` in IDLE or GAP is ignored.
- A requester that drops `req` before its grant is skipped with no side effects.
- `req` from the current owner during WAIT or GAP is ignored until IDLE.
- A single active requester may be granted on consecutive arbitrations.
- Reset values:
  - state IDLE.
  - `last_id=NUM_REQ-1`, so requester 0 has top priority after reset.
  - `gnt=0`, `tx_load=0`, `tx_data=0`, `cur_id=0`, `busy=0`, `err_timeout=0`.
  - Gap and watchdog counters are 0.
- Reset mid-WAIT abandons the frame. The transmitter must share the same reset; the arbiter does not issue a grant on the reset cycle.

## Timing
- `req` seen high in IDLE at edge t: `gnt` and `tx_load` are high during cycle t+1, and `busy` is high from t+1.
- `tx_done` seen in WAIT at edge d:
  - with `GAP_CYCLES=0`: IDLE at d+1, earliest next `gnt` at d+2.
  - with gap `G`: IDLE at d+1+G, earliest next `gnt` at d+2+G.
- `gnt` and `tx_load` are never high on two consecutive cycles.
- At most one `tx_load` is issued per `tx_done` (or per watchdog abort).
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro: `UART_TX_ARB_TIMEOUT_EN`.
- Defined:
  - A 16-bit counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches `TIMEOUT_CYCLES` before `tx_done` arrives, `err_timeout` pulses for one cycle and the state goes to GAP or IDLE exactly as for `tx_done`.
  - If `tx_done` arrives on that same cycle, `tx_done` wins and there is no error.
- Undefined:
  - No counter is built; WAIT waits indefinitely.
  - `err_timeout` is tied to 0.

## Test plan
- Single request: `req=4'b0100`, `req_data` byte2 = 0xA5 → next cycle `gnt=4'b0100`, `tx_load=1`, `tx_data=0xA5`, `cur_id=2`. After `tx_done`, `busy` falls one cycle later.
- Simultaneous requests: `req=4'b1111` held; return `tx_done` 10 cycles after each load → grant order 0, 1, 2, 3, 0.
- Fairness: `req=4'b0011` held → grants alternate 0, 1, 0, 1; one `tx_load` per `tx_done`. Check that a stray `tx_done` in IDLE causes no grant.
- Gap: `GAP_CYCLES=3`, `tx_done` at edge d → `busy` low at d+4, next `gnt` at d+5.
- Watchdog (macro defined, `TIMEOUT_CYCLES=20`): grant, then no `tx_done` → `err_timeout` pulses 20 cycles into WAIT, then IDLE. With the macro undefined, `busy` stays high.
- Reset mid-WAIT: `rst_n=0` for one edge → all outputs at reset values on the next cycle. After release with `req=4'b1001`, requester 0 is granted first.
